machine_timer: RTL
==================

Name: machine_timer

Overview:
- Memory-mapped RISC-V machine timer (mtime plus per-hart mtimecmp) for the hart data bus.
- Generalises the hart's single mtime/mtimecmp pair to NUM_HARTS comparators, with a prescaler, byte-lane writes and registered timer interrupts.
- Slave on the same stb/we/sel/addr/data bus the hart drives in NORMAL_MODE.
- The SoC decoder qualifies i_wb_stb by base address; only i_wb_addr[11:0] is decoded here.

Parameters:
NUM_HARTS, 2, number of mtimecmp registers and irq outputs (1..255)
PRESCALE, 1, clk cycles per mtime increment (>=1); 1 means increment every cycle
CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every mtimecmp

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous, active-high reset
i_wb_stb  in  1  access strobe; one access per asserted cycle
i_wb_we  in  1  1 = write, 0 = read
i_wb_sel  in  4  byte-lane enables for writes; ignored on reads
i_wb_addr  in  12  byte offset, word aligned; bits [1:0] ignored
i_wb_data  in  32  write data
o_wb_data  out  32  registered read data
o_wb_ack  out  1  access acknowledge
i_time_halt  in  1  freeze mtime and prescaler (debug)
o_timer_irq  out  NUM_HARTS  per-hart machine timer interrupt pending

Behaviour:
- Clock/reset: single clock clk. rst is asynchronous, active-high.
- On rst: mtime=0, prescaler=0, all mtimecmp=CMP_RESET, o_timer_irq=0, o_wb_ack=0, o_wb_data=0.
- Register map (word offsets):
  - 0x000 = mtime[31:0]
  - 0x004 = mtime[63:32]
  - 0x008+8h = mtimecmp[h][31:0]
  - 0x00C+8h = mtimecmp[h][63:32], for h < NUM_HARTS
  - All other offsets are unmapped.
- Bus handshake:
  - Every cycle with i_wb_stb=1 is one access.
  - o_wb_ack=1 exactly one cycle later, for one cycle per access.
  - Back-to-back strobes give back-to-back acks.
  - Unmapped accesses are still acked. Unmapped reads return 0; unmapped writes are ignored.
- Reads: o_wb_data is registered and valid in the ack cycle. It holds its value when ack=0.
- Writes: each byte lane k with i_wb_sel[k]=1 updates byte k of the addressed word. Other lanes are unchanged. The new value is visible to a read issued on the next cycle.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - mtime increments by 1 in the cycle the prescaler is at PRESCALE-1.
  - With i_time_halt=1, neither the prescaler nor mtime changes.
  - mtime wraps from 2^64-1 to 0.
- Write to mtime in the same cycle as an increment:
  - The written value wins.
  - No increment or carry is applied to either half that cycle.
  - The prescaler is not reset.
- Interrupts:
  - o_timer_irq[h] is registered: at each posedge it takes (mtime >= mtimecmp[h]), unsigned 64-bit, using pre-edge register values.
  - Latency is one cycle after the compare condition becomes true.
  - Clearing happens by writing mtimecmp: the irq drops one cycle after the write edge if the new value is greater than mtime.
  - Writing a single 32-bit half may transiently assert or deassert irq; this is not filtered, and software writes hi first.
- Reset mid-access: rst asserted while stb is pending drops ack immediately. The access is lost and no state is partially written.

Optional Feature:
- Macro MTIME_LATCH_EN.
- Defined:
  - A read of 0x000 also captures the pre-edge mtime[63:32] into a 32-bit shadow register.
  - A read of 0x004 returns the shadow, so a lo-then-hi read pair is atomic across carry.
  - The shadow resets to 0.
- Undefined:
  - No shadow register exists.
  - A read of 0x004 returns live mtime[63:32].

Test Plan:
- Reset then idle 10 cycles with PRESCALE=1 -> read 0x000 issued at cycle 10 returns 10 (±1 per bus latency, checked exactly against the model); o_timer_irq=0.
- Write 0x008=5, 0x00C=0 (sel=4'hF) after reset -> o_timer_irq[0] rises one cycle after mtime reaches 5; o_timer_irq[1] stays 0.
- Write 0x000=32'hFFFF_FFFF, 0x004=0, then let mtime run -> 0x004 reads 1 after the carry.
- With MTIME_LATCH_EN, read 0x000 on the carry cycle -> the 0x004 read returns the pre-carry value; without the macro it returns the live value.
- Byte-lane write: 0x010=32'hAABBCCDD with sel=4'b0101 over a reset value of all ones -> mtimecmp[1][31:0] reads 32'hFFBBFFDD.
- PRESCALE=4 with i_time_halt pulsed for 3 cycles -> mtime advances 1 per 4 unhalted cycles. An unmapped read at 0x100 returns 0 with ack. rst asserted mid-burst -> ack=0 and irq=0 immediately.

Source files
------------

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V machine timer with one free-running
// 64-bit mtime and NUM_HARTS 64-bit mtimecmp comparators.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_wb_stb/we     one access per strobed cycle, we=1 write
//   i_wb_sel        byte-lane enables for writes
//   i_wb_addr       byte offset; [11:2] selects the word, [1:0] ignored
//   i_wb_data       write data
//   o_wb_data       registered read data, held between reads
//   o_wb_ack        one-cycle acknowledge, one cycle after each strobe
//   i_time_halt     freezes mtime and the prescaler
//   o_timer_irq     per-hart registered (mtime >= mtimecmp[h])
//
// Word map: 0 mtime lo, 1 mtime hi, 2+2h mtimecmp[h] lo, 3+2h mtimecmp[h] hi.
//
// Optional build macro MTIME_LATCH_EN: a read of mtime lo snapshots mtime hi
// into a shadow register, and reads of mtime hi return that shadow so a
// lo-then-hi read pair is coherent across a carry.
module machine_timer #(
  parameter int unsigned NUM_HARTS = 2,
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [3:0]           i_wb_sel,
  input  logic [11:0]          i_wb_addr,
  input  logic [31:0]          i_wb_data,
  output logic [31:0]          o_wb_data,
  output logic                 o_wb_ack,
  input  logic                 i_time_halt,
  output logic [NUM_HARTS-1:0] o_timer_irq
);

  localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  // Replace the bytes of old_v whose lane enable is set with those of new_v.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = new_v[8*k +: 8];
      else        res[8*k +: 8] = old_v[8*k +: 8];
    end
    return res;
  endfunction

  logic [63:0]          r_mtime;
  logic [PW-1:0]        r_presc;
  logic [63:0]          r_cmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] r_irq;
  logic                 r_ack;
  logic [31:0]          r_rdata;

  logic [9:0]           w_word;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_mtime_lo_we;
  logic                 w_mtime_hi_we;
  logic                 w_tick;
  logic [NUM_HARTS-1:0] w_cmp_lo_we;
  logic [NUM_HARTS-1:0] w_cmp_hi_we;
  logic [31:0]          w_mtime_hi_rd;
  logic [31:0]          w_rdata;
  logic                 w_unused_addr;

  assign w_word        = i_wb_addr[11:2];
  assign w_unused_addr = ^i_wb_addr[1:0];
  assign w_rd          = i_wb_stb & ~i_wb_we;
  // A write with no lanes enabled changes nothing, so it must not
  // suppress the mtime increment either.
  assign w_wr          = i_wb_stb & i_wb_we & (|i_wb_sel);
  assign w_mtime_lo_we = w_wr & (w_word == 10'd0);
  assign w_mtime_hi_we = w_wr & (w_word == 10'd1);
  assign w_tick        = ~i_time_halt & (r_presc == PRESC_LAST);

  // Per-hart comparator write enables.
  always_comb begin
    w_cmp_lo_we = '0;
    w_cmp_hi_we = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_cmp_lo_we[h] = w_wr & (w_word == 10'(2 + 2 * h));
      w_cmp_hi_we[h] = w_wr & (w_word == 10'(3 + 2 * h));
    end
  end

`ifdef MTIME_LATCH_EN
  logic [31:0] r_shadow;

  // Shadow of mtime hi, captured (pre-edge) by every read of mtime lo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_shadow <= 32'd0;
    else if (w_rd && w_word == 10'd0) r_shadow <= r_mtime[63:32];
    else                              r_shadow <= r_shadow;
  end

  assign w_mtime_hi_rd = r_shadow;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  // Read mux; unmapped words read as zero.
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      10'd0:   w_rdata = r_mtime[31:0];
      10'd1:   w_rdata = w_mtime_hi_rd;
      default: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          w_rdata = w_rdata
                  | ((w_word == 10'(2 + 2 * h)) ? r_cmp[h][31:0]  : 32'd0)
                  | ((w_word == 10'(3 + 2 * h)) ? r_cmp[h][63:32] : 32'd0);
        end
      end
    endcase
  end

  // Prescaler: counts 0..PRESCALE-1 while not halted; never reset by writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_presc <= PW'(0);
    else if (!i_time_halt) r_presc <= (r_presc == PRESC_LAST) ? PW'(0) : r_presc + PW'(1);
    else                   r_presc <= r_presc;
  end

  // mtime: a software write to either half takes priority and cancels the
  // increment (and any carry) for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= 64'd0;
    end else if (w_mtime_lo_we || w_mtime_hi_we) begin
      r_mtime[31:0]  <= w_mtime_lo_we ? merge_lanes(r_mtime[31:0],  i_wb_data, i_wb_sel) : r_mtime[31:0];
      r_mtime[63:32] <= w_mtime_hi_we ? merge_lanes(r_mtime[63:32], i_wb_data, i_wb_sel) : r_mtime[63:32];
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end else begin
      r_mtime <= r_mtime;
    end
  end

  // mtimecmp registers with byte-lane writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HARTS; h++) r_cmp[h] <= CMP_RESET;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        r_cmp[h][31:0]  <= w_cmp_lo_we[h] ? merge_lanes(r_cmp[h][31:0],  i_wb_data, i_wb_sel) : r_cmp[h][31:0];
        r_cmp[h][63:32] <= w_cmp_hi_we[h] ? merge_lanes(r_cmp[h][63:32], i_wb_data, i_wb_sel) : r_cmp[h][63:32];
      end
    end
  end

  // Interrupts compare pre-edge mtime against pre-edge mtimecmp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) r_irq[h] <= (r_mtime >= r_cmp[h]);
    end
  end

  // Bus response: ack every strobe one cycle later; data only moves on reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= i_wb_stb;
      r_rdata <= w_rd ? w_rdata : r_rdata;
    end
  end

  assign o_wb_ack    = r_ack;
  assign o_wb_data   = r_rdata;
  assign o_timer_irq = r_irq;

endmodule
